// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. All channels share one counter; each channel
// compares the counter against its own duty value. Period, duties and the
// alignment mode are written into shadow registers by a one-cycle load strobe
// and only become active at a period boundary (or immediately while idle), so
// an output never sees a half-old/half-new setting.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         run enable; low holds the counter at 0 and forces outputs low
//   load       one-cycle strobe: capture period/duty/center into shadow
//   period     period setting P
//   duty       channel i duty at bits [i*WIDTH +: WIDTH]
//   center     0 = edge-aligned, 1 = center-aligned
//   pout       registered PWM outputs, one per channel
//   period_end registered one-cycle pulse on the last cycle of each period
//   pending    shadow holds values not yet applied
// -----------------------------------------------------------------------------
module pwm_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      load,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      center,
   output logic [CHANNELS-1:0]       pout,
   output logic                      period_end,
   output logic                      pending
);

   // Shared counter state. dir_down_reg = 0 means counting up.
   logic [WIDTH-1:0]    cnt_reg, cnt_next;
   logic                dir_down_reg, dir_down_next;

   // Active and shadow copies of the shared settings.
   logic [WIDTH-1:0]    period_act_reg, period_sh_reg;
   logic                center_act_reg, center_sh_reg;

   logic                pending_reg, pending_next;
   logic [CHANNELS-1:0] pout_reg, pout_next;
   logic                period_end_reg;

   logic                last_count;
   logic                boundary;
   logic                xfer;
   logic [WIDTH-1:0]    period_m1;

   assign period_m1 = period_act_reg - WIDTH'(1);

   // Last cycle of a period. In center mode with P=0 the counter is parked at
   // 0 going up, so this never fires and no period ever completes.
   always_comb begin
      if (center_act_reg)
         last_count = dir_down_reg && (cnt_reg == '0) && (period_act_reg != '0);
      else
         last_count = (cnt_reg == period_act_reg);
   end

   assign boundary = en & last_count;

   // Shadow-to-active copy happens at a running boundary, or on any clock
   // while idle if something is waiting, so idle loads apply within a cycle.
   assign xfer = boundary | (~en & pending_reg);

   // A load always wins over the clear: if it lands on a boundary, the copy
   // takes the old shadow and the new values wait for the next boundary.
   always_comb begin
      pending_next = pending_reg;
      if (load)
         pending_next = 1'b1;
      else if (xfer)
         pending_next = 1'b0;
   end

   // Counter sequencing. Center mode repeats each endpoint once: up 0..P-1,
   // P-1 again while turning, down to 0, and the repeated 0 is the first
   // cycle of the next period.
   always_comb begin
      cnt_next      = cnt_reg;
      dir_down_next = dir_down_reg;
      if (!en || boundary) begin
         cnt_next      = '0;
         dir_down_next = 1'b0;
      end else if (center_act_reg) begin
         if (period_act_reg == '0) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
         end else if (!dir_down_reg) begin
            if (cnt_reg == period_m1)
               dir_down_next = 1'b1;
            else
               cnt_next = cnt_reg + WIDTH'(1);
         end else begin
            // cnt_reg > 0 here; cnt_reg == 0 going down is a boundary.
            cnt_next = cnt_reg - WIDTH'(1);
         end
      end else begin
         // Edge mode: cnt_reg < P here, so the increment cannot overflow.
         cnt_next = cnt_reg + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg        <= '0;
         dir_down_reg   <= 1'b0;
         period_act_reg <= '0;
         period_sh_reg  <= '0;
         center_act_reg <= 1'b0;
         center_sh_reg  <= 1'b0;
         pending_reg    <= 1'b0;
         pout_reg       <= '0;
         period_end_reg <= 1'b0;
      end else begin
         cnt_reg        <= cnt_next;
         dir_down_reg   <= dir_down_next;
         pending_reg    <= pending_next;
         pout_reg       <= pout_next;
         period_end_reg <= boundary;
         if (load) begin
            period_sh_reg <= period;
            center_sh_reg <= center;
         end
         if (xfer) begin
            period_act_reg <= period_sh_reg;
            center_act_reg <= center_sh_reg;
         end
      end
   end

   // Per-channel duty storage and compare.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [WIDTH-1:0] duty_sh_reg;
         logic [WIDTH-1:0] duty_act_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               duty_sh_reg  <= '0;
               duty_act_reg <= '0;
            end else begin
               if (load)
                  duty_sh_reg <= duty[gi*WIDTH +: WIDTH];
               if (xfer)
                  duty_act_reg <= duty_sh_reg;
            end
         end

         assign pout_next[gi] = en & (cnt_reg < duty_act_reg);
      end
   endgenerate

   assign pout       = pout_reg;
   assign period_end = period_end_reg;
   assign pending    = pending_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//
// Directed bench for pwm_multi (WIDTH=8, CHANNELS=4). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, so each
// sample shows the registered result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

   localparam int W  = 8;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          load;
   logic [W-1:0]  period;
   logic [CH*W-1:0] duty;
   logic          center;
   logic [CH-1:0] pout;
   logic          period_end;
   logic          pending;

   int total = 0;
   int bad   = 0;

   int hi [CH];
   int pe_n;
   int acc;
   logic [15:0] pat_p;
   logic [15:0] pat_pe;

   pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .period     (period),
      .duty       (duty),
      .center     (center),
      .pout       (pout),
      .period_end (period_end),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count high samples per channel and period_end pulses over n cycles.
   task automatic win(input int n);
      for (int c = 0; c < CH; c++) hi[c] = 0;
      pe_n = 0;
      for (int k = 0; k < n; k++) begin
         step();
         for (int c = 0; c < CH; c++) hi[c] += int'(pout[c]);
         pe_n += int'(period_end);
      end
   endtask

   // Step until a period_end sample, giving up after lim cycles.
   task automatic wait_pe(input string tag, input int lim);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!period_end && k < lim);
      chk(tag, period_end, 1);
   endtask

   // Program while idle: pending rises on the load edge and clears one edge later.
   task automatic prog_idle(input string tag, input logic [W-1:0] p,
                            input logic [CH*W-1:0] d, input logic c);
      en = 1'b0; load = 1'b1; period = p; duty = d; center = c;
      step();
      load = 1'b0;
      chk({tag, "_pend_set"}, pending, 1);
      step();
      chk({tag, "_pend_clr"}, pending, 0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0; center = 1'b0;
      #3;
      chk("rst_pout", pout, 0);
      chk("rst_pe", period_end, 0);
      chk("rst_pending", pending, 0);
      #18;
      rst = 1'b0;
      step();

      // 1: edge mode, P=9, duty {255,10,3,0}
      prog_idle("t1", 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 1'b0);
      en = 1'b1;
      wait_pe("t1_wait", 40);
      win(10);
      chk("t1_ch0", hi[0], 0);
      chk("t1_ch1", hi[1], 3);
      chk("t1_ch2", hi[2], 10);
      chk("t1_ch3", hi[3], 10);
      chk("t1_pe_cnt", pe_n, 1);
      chk("t1_pe_last", period_end, 1);

      // 4: idle load P=5 duty 3, enable two cycles after the load
      prog_idle("t4", 8'd5, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
      chk("t4_idle_low", pout, 0);
      en = 1'b1;
      step();
      chk("t4_first_high", pout[0], 1);
      win(5);
      chk("t4_rest_hi", hi[0], 2);
      chk("t4_pe_last", period_end, 1);
      win(6);
      chk("t4_full_hi", hi[0], 3);
      chk("t4_full_pe", pe_n, 1);

      // 2: center mode, P=4, duty 2 -> pattern over counts 0,1,2,3,3,2,1,0
      prog_idle("t2", 8'd4, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1);
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         pat_p[i]  = pout[0];
         pat_pe[i] = period_end;
      end
      chk("t2_pout_pat", pat_p, 16'b1100_0011_1100_0011);
      chk("t2_pe_pat", pat_pe, 16'b1000_0000_1000_0000);

      // 3: mid-period load applies only at the next boundary
      prog_idle("t3", 8'd9, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b0);
      en = 1'b1;
      wait_pe("t3_wait", 40);
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         acc += int'(pout[0]);
      end
      load = 1'b1; duty = {8'd0, 8'd0, 8'd0, 8'd7};
      step();
      load = 1'b0;
      acc += int'(pout[0]);
      chk("t3_pend_set", pending, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         acc += int'(pout[0]);
      end
      chk("t3_pend_hold", pending, 1);
      step();
      acc += int'(pout[0]);
      chk("t3_pe", period_end, 1);
      chk("t3_pend_clr", pending, 0);
      chk("t3_old_hi", acc, 2);
      step();
      chk("t3_new_first", pout[0], 1);
      win(9);
      chk("t3_new_hi", hi[0], 6);
      chk("t3_new_pe", period_end, 1);

      // 5: load on the boundary cycle is deferred by one period
      for (int k = 0; k < 9; k++) step();
      load = 1'b1; duty = {8'd0, 8'd0, 8'd0, 8'd4};
      step();
      load = 1'b0;
      chk("t5_pe", period_end, 1);
      chk("t5_pend_stay", pending, 1);
      win(10);
      chk("t5_old_hi", hi[0], 7);
      chk("t5_pe_last", period_end, 1);
      chk("t5_pend_clr", pending, 0);
      win(10);
      chk("t5_new_hi", hi[0], 4);

      // Full-scale edge period P=255: 256 cycles
      prog_idle("tmax", 8'd255, {8'd0, 8'd0, 8'd1, 8'd255}, 1'b0);
      en = 1'b1;
      wait_pe("tmax_wait", 300);
      win(256);
      chk("tmax_ch0", hi[0], 255);
      chk("tmax_ch1", hi[1], 1);
      chk("tmax_pe_cnt", pe_n, 1);
      chk("tmax_pe_last", period_end, 1);

      // 6: asynchronous reset mid-period
      prog_idle("t6", 8'd9, {8'd0, 8'd0, 8'd0, 8'd4}, 1'b0);
      en = 1'b1;
      wait_pe("t6_wait", 40);
      step();
      chk("t6_pre_high", pout[0], 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_pout", pout, 0);
      chk("t6_async_pe", period_end, 0);
      chk("t6_async_pend", pending, 0);
      step();
      rst = 1'b0;
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         acc += int'(pout != '0);
      end
      chk("t6_low_after", acc, 0);
      load = 1'b1; period = 8'd3; duty = {8'd0, 8'd0, 8'd0, 8'd2}; center = 1'b0;
      step();
      load = 1'b0;
      chk("t6_k_pend", pending, 1);
      chk("t6_k_pout", pout[0], 0);
      step();
      chk("t6_k1_pout", pout[0], 0);
      chk("t6_k1_pend", pending, 0);
      chk("t6_k1_pe", period_end, 1);
      step();
      chk("t6_k2_pout", pout[0], 1);
      step();
      chk("t6_k3_pout", pout[0], 1);
      step();
      chk("t6_k4_pout", pout[0], 0);
      step();
      chk("t6_k5_pout", pout[0], 0);
      chk("t6_k5_pe", period_end, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel 8-bit PWM.
- Adds per-channel duty, a programmable period, and edge- or center-aligned mode.
- Shadow registers give glitch-free updates that take effect only at period boundaries.
- Sits between a control register bank (duty/period writes) and motor/LED/audio output pins.

Parameters:
- WIDTH, 8, bit width of counter, period and each duty value.
- CHANNELS, 4, number of independent PWM outputs sharing one counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run enable; 0 holds counter at 0 and outputs low.
- load  input  1  one-cycle strobe: capture period/duty/center into shadow registers.
- period  input  WIDTH  period setting P.
- duty  input  CHANNELS*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH].
- center  input  1  0 = edge-aligned, 1 = center-aligned.
- pout  output  CHANNELS  registered PWM outputs.
- period_end  output  1  registered one-cycle pulse on the last cycle of each period.
- pending  output  1  shadow holds values not yet applied.

Behaviour:
- Reset (async, immediate, no clock needed):
  - cnt=0, dir=up.
  - Active and shadow period/duty/center = 0.
  - pout=0, period_end=0, pending=0.
- Edge mode, active period P:
  - cnt runs 0,1..P then wraps to 0; period length is P+1 cycles.
  - Last count is cnt==P.
- Center mode, active period P:
  - cnt runs up 0..P-1, repeats P-1, runs down to 0, then repeats 0 and goes up again; period length is 2P cycles.
  - dir flips after the repeated endpoint cycle.
  - Last count is dir=down and cnt==0.
  - If P==0: cnt held at 0, pout=0, period_end never pulses.
- Output compare:
  - Next-cycle pout[i] = en & (cnt < duty_act[i]).
  - Registered, so pout lags cnt by exactly 1 cycle.
  - Edge mode: high cycles per period = min(duty, P+1). duty=0 gives constant low; duty>P gives constant high.
  - Center mode: high cycles = 2*min(duty, P), contiguous and centered on the period wrap.
- period_end:
  - Registered from (en & last count), so it coincides with the pout value of the period's final cycle.
- Shadow/load:
  - load=1 writes period, duty and center into the shadow registers and sets pending=1.
  - At a boundary (en=1 and last count), shadow is copied to active, cnt restarts at 0 with dir=up, and pending clears.
  - While en=0, a pending shadow is copied to active on the next clock, so a load while idle applies within 1 cycle.
  - If load coincides with a boundary: the boundary copies the pre-load shadow contents; the new values land in shadow; pending stays 1 and they apply at the next boundary.
  - Mode change (center toggle) takes effect only via this boundary transfer; never mid-period.
- Enable:
  - en falling: next cycle cnt=0, dir=up, pout=0, period_end=0. Active values are retained.
  - en rising: first clock uses cnt=0, so pout reflects count 0 one cycle after en.
- Arithmetic: all compares unsigned WIDTH-bit. Counter never exceeds P, so there is no overflow, including at P=2^WIDTH-1 (edge period 256 cycles).

Test Plan:
1. Edge mode, WIDTH=8, P=9, duty={255,10,3,0} (ch3..ch0), en=1, after load and boundary -> each 10-cycle period: ch0 high 0 cycles, ch1 high 3, ch2 high 10, ch3 high 10; period_end every 10th cycle.
2. Center mode, P=4, ch0 duty=2 -> period 8 cycles; pout[0] high for 4 contiguous cycles straddling the wrap (counts 1,0,0,1); period_end once per 8 cycles.
3. Edge P=9, ch0 duty=2 running; load duty=7 at cycle 4 of a period -> pending=1; remainder of that period still 2 high; the next period is 7 high starting exactly after period_end; pending clears at the boundary.
4. en=0, load P=5 duty=3, then en=1 two cycles later -> active updated while idle (pending=0 before en); first pout high one cycle after en; 3 of every 6 cycles high.
5. Load asserted in the same cycle as a boundary -> new value not used in the following period; it applies one period later; pending stays 1 across the boundary.
6. Assert rst mid-period with pout=1, between clock edges -> pout and period_end drop to 0 immediately; after release and with en=1, outputs stay low until a load and boundary program non-zero duty.
